// File: rtl/lsu_stage.sv
// lsu_stage: memory-access stage between execute and commit.
// Holds one instruction at a time, issues a single request on the req/resp
// memory bus for loads/stores, aligns and extends load data, and hands the
// result plus the passthrough writeback/CSR bundles to commit.
module lsu_stage #(
    parameter int RESP_TIMEOUT = 256
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         valid_pre_i,
    output logic         ready_pre_o,
    output logic         valid_post_o,
    input  logic         ready_post_i,
    input  logic [70:0]  wb_bundle_i,
    input  logic [72:0]  csr_bundle_i,
    input  logic [31:0]  alu_result_i,
    input  logic         mem_ren_i,
    input  logic         mem_wen_i,
    input  logic [2:0]   mem_op_i,
    input  logic [31:0]  store_data_i,
    output logic [70:0]  wb_bundle_o,
    output logic [72:0]  csr_bundle_o,
    output logic [31:0]  alu_result_o,
    output logic [31:0]  mem_result_o,
    output logic         lsu_err_o,
    output logic         mem_req_valid_o,
    input  logic         mem_req_ready_i,
    output logic         mem_req_we_o,
    output logic [31:0]  mem_req_addr_o,
    output logic [31:0]  mem_req_wdata_o,
    output logic [3:0]   mem_req_wstrb_o,
    input  logic         mem_resp_valid_i,
    input  logic [31:0]  mem_resp_rdata_i,
    input  logic         mem_resp_err_i
);

    localparam int CW = $clog2(RESP_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(RESP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [70:0]   r_wb;
    logic [72:0]   r_csr;
    logic [31:0]   r_alu;
    logic [31:0]   r_mem_result;
    logic          r_err;
    logic          r_ren;
    logic [2:0]    r_op;
    logic          r_req_we;
    logic [31:0]   r_req_addr;
    logic [31:0]   r_req_wdata;
    logic [3:0]    r_req_wstrb;
    logic [CW-1:0] r_cnt;

    logic          w_capture;
    logic          w_is_mem;
    logic [2:0]    w_size;
    logic [1:0]    w_off;
    logic          w_misaligned;
    logic          w_issue;
    logic          w_accept;
    logic          w_resp;
    logic          w_timeout;
    logic [3:0]    w_wstrb_next;
    logic [31:0]   w_wdata_next;
    logic [31:0]   w_shifted;
    logic [31:0]   w_load;

    // Handshake outputs depend on state only, never on ready_post_i.
    assign ready_pre_o     = (r_state == S_IDLE);
    assign valid_post_o    = (r_state == S_DONE);
    assign mem_req_valid_o = (r_state == S_REQ);

    assign wb_bundle_o     = r_wb;
    assign csr_bundle_o    = r_csr;
    assign alu_result_o    = r_alu;
    assign mem_result_o    = r_mem_result;
    assign lsu_err_o       = r_err;
    assign mem_req_we_o    = r_req_we;
    assign mem_req_addr_o  = r_req_addr;
    assign mem_req_wdata_o = r_req_wdata;
    assign mem_req_wstrb_o = r_req_wstrb;

    // Access decode: size in bytes from funct3[1:0]; the bus only sees aligned accesses.
    assign w_capture    = valid_pre_i && (r_state == S_IDLE);
    assign w_is_mem     = mem_ren_i || mem_wen_i;
    assign w_off        = alu_result_i[1:0];
    assign w_size       = (mem_op_i[1:0] == 2'b00) ? 3'd1 :
                          (mem_op_i[1:0] == 2'b01) ? 3'd2 : 3'd4;
    assign w_misaligned = ((w_size == 3'd2) && alu_result_i[0]) ||
                          ((w_size == 3'd4) && (w_off != 2'b00));
    assign w_issue      = w_is_mem && !w_misaligned;
    assign w_accept     = (r_state == S_REQ) && mem_req_ready_i;
    assign w_resp       = (r_state == S_WAIT) && mem_resp_valid_i;
    assign w_timeout    = (r_state == S_WAIT) && !mem_resp_valid_i && (r_cnt == CNT_LAST);

    // A byte lane is written when it falls inside [offset, offset+size) of a store.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_wstrb_next[gi] = mem_wen_i &&
                                      (3'(gi) >= {1'b0, w_off}) &&
                                      (3'(gi) <  ({1'b0, w_off} + w_size));
        end
    endgenerate

    assign w_wdata_next = mem_wen_i ? (store_data_i << {w_off, 3'b000}) : 32'd0;

    // Load extraction: shift the addressed bytes down, then sign/zero extend.
    assign w_shifted = mem_resp_rdata_i >> {r_alu[1:0], 3'b000};
    always_comb begin
        w_load = w_shifted;
        case (r_op)
            3'b000:  w_load = {{24{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {24'd0, w_shifted[7:0]};
            3'b101:  w_load = {16'd0, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    // Next-state logic for IDLE -> {DONE|REQ} -> WAIT -> DONE -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_capture) w_state_next = w_issue ? S_REQ : S_DONE;
            S_REQ:  if (w_accept) w_state_next = S_WAIT;
            S_WAIT: if (w_resp || w_timeout) w_state_next = S_DONE;
            S_DONE: if (ready_post_i) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register; reset abandons anything in flight.
    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Response timeout counter, restarted on capture and on request acceptance.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_capture || w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT) && !mem_resp_valid_i && (r_cnt != CNT_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Instruction capture, request fields and result/error registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wb         <= '0;
            r_csr        <= '0;
            r_alu        <= '0;
            r_mem_result <= '0;
            r_err        <= 1'b0;
            r_ren        <= 1'b0;
            r_op         <= '0;
            r_req_we     <= 1'b0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_req_wstrb  <= '0;
        end else if (w_capture) begin
            r_wb         <= wb_bundle_i;
            r_csr        <= csr_bundle_i;
            r_alu        <= alu_result_i;
            r_ren        <= mem_ren_i;
            r_op         <= mem_op_i;
            r_mem_result <= '0;
            r_err        <= w_is_mem && w_misaligned;
            // Request fields only carry meaning for an access that reaches the bus.
            r_req_we     <= w_issue && mem_wen_i;
            r_req_addr   <= w_issue ? {alu_result_i[31:2], 2'b00} : 32'd0;
            r_req_wdata  <= w_issue ? w_wdata_next : 32'd0;
            r_req_wstrb  <= w_issue ? w_wstrb_next : 4'd0;
        end else if (w_resp) begin
            r_err        <= mem_resp_err_i;
            r_mem_result <= (r_ren && !mem_resp_err_i) ? w_load : 32'd0;
        end else if (w_timeout) begin
            r_err        <= 1'b1;
            r_mem_result <= '0;
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: randomized scoreboard bench for lsu_stage with a byte-level
// memory reference model, a memory responder and a decoupled result monitor.
`timescale 1ns/1ps
module tb_lsu_stage;

    localparam int TO = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         valid_pre_i = 1'b0;
    logic         ready_pre_o;
    logic         valid_post_o;
    logic         ready_post_i = 1'b0;
    logic [70:0]  wb_bundle_i = '0;
    logic [72:0]  csr_bundle_i = '0;
    logic [31:0]  alu_result_i = '0;
    logic         mem_ren_i = 1'b0;
    logic         mem_wen_i = 1'b0;
    logic [2:0]   mem_op_i = '0;
    logic [31:0]  store_data_i = '0;
    logic [70:0]  wb_bundle_o;
    logic [72:0]  csr_bundle_o;
    logic [31:0]  alu_result_o;
    logic [31:0]  mem_result_o;
    logic         lsu_err_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i = 1'b0;
    logic         mem_req_we_o;
    logic [31:0]  mem_req_addr_o;
    logic [31:0]  mem_req_wdata_o;
    logic [3:0]   mem_req_wstrb_o;
    logic         mem_resp_valid_i = 1'b0;
    logic [31:0]  mem_resp_rdata_i = '0;
    logic         mem_resp_err_i = 1'b0;

    lsu_stage #(.RESP_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
        .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
        .wb_bundle_i(wb_bundle_i), .csr_bundle_i(csr_bundle_i),
        .alu_result_i(alu_result_i), .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i),
        .mem_op_i(mem_op_i), .store_data_i(store_data_i),
        .wb_bundle_o(wb_bundle_o), .csr_bundle_o(csr_bundle_o),
        .alu_result_o(alu_result_o), .mem_result_o(mem_result_o), .lsu_err_o(lsu_err_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wstrb_o(mem_req_wstrb_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_rdata_i(mem_resp_rdata_i),
        .mem_resp_err_i(mem_resp_err_i)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [70:0] wb;
        logic [72:0] csr;
        logic [31:0] alu;
        logic [31:0] res;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
        int          rdy;
        int          resp;
        bit          err;
        bit          noresp;
        bit          late;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cap_cyc = 0;
    int ready_mode = 0;   // 0 random, 1 held low, 2 held high
    bit resp_busy = 1'b0;
    int txn_no = 0;

    logic [7:0]  mref  [0:63];   // reference memory, byte addressed
    logic [31:0] mem_w [0:15];   // responder memory, word addressed

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s act=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] w);
        mem_w[idx] = w;
        for (int b = 0; b < 4; b++) mref[idx*4 + b] = w[8*b +: 8];
    endtask

    // Commit-side ready generator.
    always @(posedge clock) begin
        #1;
        if (ready_mode == 1)      ready_post_i = 1'b0;
        else if (ready_mode == 2) ready_post_i = 1'b1;
        else                      ready_post_i = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compares every cycle a result is offered; pops on acceptance.
    bit   prev_valid = 1'b0;
    exp_t m_e;
    always @(negedge clock) begin
        if (reset && valid_post_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 73'(valid_post_o), 73'(0));
            end else begin
                m_e = exp_q[0];
                if (!prev_valid) chk("latency", 73'(cyc - cap_cyc + 1), 73'(m_e.lat));
                chk("wb_bundle", 73'(wb_bundle_o), 73'(m_e.wb));
                chk("csr_bundle", csr_bundle_o, m_e.csr);
                chk("alu_result", 73'(alu_result_o), 73'(m_e.alu));
                chk("mem_result", 73'(mem_result_o), 73'(m_e.res));
                chk("lsu_err", 73'(lsu_err_o), 73'(m_e.err));
                if (ready_post_i) begin
                    void'(exp_q.pop_front());
                    txn_no++;
                    $display("txn %0d alu=%08h res=%08h err=%0b lat=%0d", txn_no,
                             alu_result_o, mem_result_o, lsu_err_o, cyc - cap_cyc + 1);
                end
            end
        end
        prev_valid = valid_post_o;
    end

    // Memory responder driven by the plan queue.
    plan_t       r_p;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_we;
    initial begin
        forever begin
            @(negedge clock);
            if (reset && mem_req_valid_o) begin
                if (plan_q.size() == 0) begin
                    chk("unexpected_req", 73'(mem_req_valid_o), 73'(0));
                    r_p = '{addr: mem_req_addr_o, wdata: mem_req_wdata_o, wstrb: mem_req_wstrb_o,
                            we: mem_req_we_o, rdy: 0, resp: 0, err: 1'b1, noresp: 1'b0, late: 1'b0};
                end else begin
                    r_p = plan_q.pop_front();
                end
                for (int i = 0; i <= r_p.rdy; i++) begin
                    if (i > 0) @(negedge clock);
                    chk("req_addr", 73'(mem_req_addr_o), 73'(r_p.addr));
                    chk("req_we", 73'(mem_req_we_o), 73'(r_p.we));
                    chk("req_wstrb", 73'(mem_req_wstrb_o), 73'(r_p.wstrb));
                    if (r_p.we) chk("req_wdata", 73'(mem_req_wdata_o), 73'(r_p.wdata));
                end
                r_addr = mem_req_addr_o; r_wdata = mem_req_wdata_o;
                r_wstrb = mem_req_wstrb_o; r_we = mem_req_we_o;
                mem_req_ready_i = 1'b1;
                @(negedge clock);
                mem_req_ready_i = 1'b0;
                if (!r_p.noresp || r_p.late) begin
                    repeat (r_p.resp) @(negedge clock);
                    mem_resp_valid_i = 1'b1;
                    mem_resp_rdata_i = r_we ? $urandom() : mem_w[r_addr[5:2]];
                    mem_resp_err_i   = r_p.err;
                    if (r_we && !r_p.err && !r_p.noresp)
                        for (int b = 0; b < 4; b++)
                            if (r_wstrb[b]) mem_w[r_addr[5:2]][8*b +: 8] = r_wdata[8*b +: 8];
                    @(negedge clock);
                    mem_resp_valid_i = 1'b0;
                    mem_resp_err_i   = 1'b0;
                end
                resp_busy = 1'b0;
            end
        end
    end

    // Issue one instruction; the reference model computes the outcome from
    // byte memory and pushes the expected result (and bus plan, if any).
    task automatic issue(input bit ren, input bit wen, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [70:0] wb, input logic [72:0] csr,
                         input int rdy, input int resp, input bit perr,
                         input bit noresp, input bit late);
        exp_t e; plan_t p; int sz, off, ba, n; logic [31:0] v;
        n = 0;
        while (!(ready_pre_o && !resp_busy)) begin
            @(negedge clock);
            n++;
            if (n > 500) begin
                chk("issue_timeout", 73'(ready_pre_o), 73'(1));
                return;
            end
        end
        sz  = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        off = int'(a[1:0]);
        ba  = int'(a[5:0]);
        e.wb = wb; e.csr = csr; e.alu = a; e.res = '0; e.err = 1'b0; e.lat = 1;
        if (ren || wen) begin
            if ((ba % sz) != 0) begin
                e.err = 1'b1;
            end else begin
                e.err = perr || noresp;
                e.lat = noresp ? (2 + rdy + TO) : (3 + rdy + resp);
                p.addr  = a & 32'hFFFF_FFFC;
                p.we    = wen;
                p.wstrb = wen ? 4'(((1 << sz) - 1) << off) : 4'h0;
                p.wdata = sd << (8 * off);
                p.rdy = rdy; p.resp = resp; p.err = perr; p.noresp = noresp; p.late = late;
                if (ren && !e.err) begin
                    v = '0;
                    for (int i = 0; i < sz; i++) v |= 32'(mref[ba + i]) << (8 * i);
                    if (!op[2] && sz < 4 && v[8*sz-1]) v |= 32'hFFFF_FFFF << (8 * sz);
                    e.res = v;
                end
                if (wen && !e.err)
                    for (int i = 0; i < sz; i++) mref[ba + i] = sd[8*i +: 8];
                plan_q.push_back(p);
                resp_busy = 1'b1;
            end
        end
        exp_q.push_back(e);
        mem_ren_i = ren; mem_wen_i = wen; mem_op_i = op; alu_result_i = a;
        store_data_i = sd; wb_bundle_i = wb; csr_bundle_i = csr;
        cap_cyc = cyc + 1;
        valid_pre_i = 1'b1;
        @(negedge clock);
        valid_pre_i = 1'b0;
        mem_ren_i = 1'b0; mem_wen_i = 1'b0; alu_result_i = $urandom();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready_pre"}, 73'(ready_pre_o), 73'(1));
        chk({tag, "_valid_post"}, 73'(valid_post_o), 73'(0));
        chk({tag, "_req_valid"}, 73'(mem_req_valid_o), 73'(0));
        chk({tag, "_outputs"}, 73'({alu_result_o, mem_result_o, lsu_err_o, mem_req_we_o}), 73'(0));
        chk({tag, "_req_fields"}, 73'({mem_req_addr_o, mem_req_wstrb_o}), 73'(0));
        chk({tag, "_bundles"}, wb_bundle_o | 71'(0) | 73'(csr_bundle_o != 0), 73'(0));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((resp_busy || exp_q.size() != 0) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) chk({tag, "_drain"}, 73'(exp_q.size()), 73'(0));
    endtask

    bit          t_ren, t_wen, t_perr, t_nr, t_late;
    logic [2:0]  t_op;
    logic [31:0] t_a, t_sd;
    logic [70:0] t_wb;
    logic [72:0] t_csr;
    int          t_k, t_rdy, t_resp, n_w;

    initial begin
        for (int i = 0; i < 16; i++) set_word(i, $urandom());
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clock);

        // Non-memory ADD.
        issue(0, 0, 3'b000, 32'h0000_1234, 32'h0, 71'h1_2345_6789, 73'h5_5555, 0, 0, 0, 0, 0);
        wait_idle("add");

        // LB sign-extends the top byte.
        set_word(0, 32'h80AA_BBCC);
        issue(1, 0, 3'b000, 32'h8000_0003, 32'h0, 71'h7, 73'h9, 0, 0, 0, 0, 0);
        wait_idle("lb");

        // SH to upper half with commit stalled; the monitor checks outputs each held cycle.
        ready_mode = 1;
        issue(0, 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 71'h3, 73'h4, 1, 1, 0, 0, 0);
        n_w = 0;
        while (!valid_post_o && n_w < 100) begin @(negedge clock); n_w++; end
        chk("sh_valid_seen", 73'(valid_post_o), 73'(1));
        repeat (3) @(negedge clock);
        ready_mode = 0;
        wait_idle("sh");
        // Readback of the stored halfword.
        issue(1, 0, 3'b101, 32'h8000_0002, 32'h0, 71'h0, 73'h0, 0, 0, 0, 0, 0);
        wait_idle("lhu");

        // Misaligned LW: error, no bus request.
        issue(1, 0, 3'b010, 32'h8000_0001, 32'h0, 71'h5, 73'h6, 0, 0, 0, 0, 0);
        wait_idle("lw_mis");

        // LW timeout followed by a late response pulse that must be ignored.
        ready_mode = 2;
        issue(1, 0, 3'b010, 32'h8000_0004, 32'h0, 71'h8, 73'h8, 1, TO + 3, 0, 1, 1);
        wait_idle("timeout");
        @(negedge clock);
        chk("late_resp_valid_post", 73'(valid_post_o), 73'(0));
        chk("late_resp_ready_pre", 73'(ready_pre_o), 73'(1));
        ready_mode = 0;

        // Reset while waiting for a response.
        issue(1, 0, 3'b010, 32'h8000_0008, 32'h0, 71'hA, 73'hB, 0, 0, 0, 1, 0);
        n_w = 0;
        while (resp_busy && n_w < 100) begin @(negedge clock); n_w++; end
        repeat (2) @(negedge clock);
        chk("wait_before_reset", 73'({ready_pre_o, valid_post_o, mem_req_valid_o}), 73'(0));
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check_reset_outputs("reset_in_wait");
        reset = 1'b1;
        @(negedge clock);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            t_k = $urandom_range(0, 99);
            t_ren = (t_k < 40);
            t_wen = (t_k >= 40) && (t_k < 75);
            case ($urandom_range(0, 4))
                0: t_op = 3'b000;
                1: t_op = 3'b001;
                2: t_op = 3'b010;
                3: t_op = 3'b100;
                default: t_op = 3'b101;
            endcase
            t_a = 32'h8000_0000 | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) t_a[1:0] = 2'b00;
            if (!t_ren && !t_wen) t_a = $urandom();
            t_sd   = $urandom();
            t_wb   = 71'({$urandom(), $urandom(), $urandom()});
            t_csr  = 73'({$urandom(), $urandom(), $urandom()});
            t_rdy  = $urandom_range(0, 3);
            t_resp = $urandom_range(0, 3);
            t_perr = ($urandom_range(0, 7) == 0);
            t_nr   = ($urandom_range(0, 15) == 0);
            t_late = t_nr && ($urandom_range(0, 1) == 1);
            if (t_nr) t_resp = TO + $urandom_range(1, 3);
            issue(t_ren, t_wen, t_op, t_a, t_sd, t_wb, t_csr, t_rdy, t_resp, t_perr, t_nr, t_late);
        end
        wait_idle("final");
        chk("plan_left", 73'(plan_q.size()), 73'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
